// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage of the 3-stage RISC-V pipeline. Owns the PC,
//   drives the synchronous instruction memory (1-cycle read latency) and
//   builds the X-stage instruction/PC register.
//
//   Optional feature macro: FETCH_SKID_BUF_EN
//     defined   : a skid register captures IMemDout whenever the memory is
//                 disabled, so memories that do not retain their output
//                 while disabled are tolerated.
//     undefined : the memory must hold IMemDout while IMemEn = 0.
//
// Ports
//   Clock     in   rising-edge clock
//   Reset     in   asynchronous active-low reset
//   stall     in   global memory stall, freezes the stage
//   PCDelay   in   load-use hold: hold fetch, bubble X
//   noop      in   replace the word entering X with NOP_INST
//   PCSel     in   redirect taken in X
//   PCTarget  in   redirect target (low 2 bits ignored)
//   IMemAddr  out  fetch address (= PCF)
//   IMemEn    out  instruction memory read enable
//   IMemDout  in   read data for the previous enabled address
//   PCF       out  PC being fetched
//   InstX     out  instruction presented to X
//   PCX       out  PC of InstX
//   ValidX    out  InstX is a real instruction (0 = bubble)
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_2000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        stall,
  input  logic        PCDelay,
  input  logic        noop,
  input  logic        PCSel,
  input  logic [31:0] PCTarget,
  output logic [31:0] IMemAddr,
  output logic        IMemEn,
  input  logic [31:0] IMemDout,
  output logic [31:0] PCF,
  output logic [31:0] InstX,
  output logic [31:0] PCX,
  output logic        ValidX
);

  localparam logic [1:0] S_BOOT = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [31:0] pcf_q, pcf_d;
  logic [31:0] pcd_q, pcd_d;
  logic        dvalid_q, dvalid_d;
  logic [31:0] instx_q, instx_d;
  logic [31:0] pcx_q, pcx_d;
  logic        validx_q, validx_d;
  logic [1:0]  state_q, state_d;
  logic [31:0] word;

  assign IMemEn   = Reset & ~stall & (PCSel | ~PCDelay);
  assign IMemAddr = pcf_q;
  assign PCF      = pcf_q;
  assign InstX    = instx_q;
  assign PCX      = pcx_q;
  assign ValidX   = validx_q;

`ifdef FETCH_SKID_BUF_EN
  // skid_sel_q marks that the memory was disabled last cycle, so IMemDout
  // may be stale and the captured copy must be used instead. Only the first
  // disabled cycle captures; later ones would see garbage.
  logic [31:0] skid_inst_q, skid_inst_d;
  logic        skid_sel_q, skid_sel_d;

  always_comb begin
    skid_inst_d = skid_inst_q;
    skid_sel_d  = skid_sel_q;
    if (!IMemEn) begin
      if (!skid_sel_q) skid_inst_d = IMemDout;
      skid_sel_d = 1'b1;
    end else begin
      skid_sel_d = 1'b0;
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) skid_sel_q <= 1'b0;
    else        skid_sel_q <= skid_sel_d;
  end

  // Data-only register: contents are never used before skid_sel_q is set.
  always_ff @(posedge Clock) begin
    skid_inst_q <= skid_inst_d;
  end

  assign word = skid_sel_q ? skid_inst_q : IMemDout;
`else
  assign word = IMemDout;
`endif

  // Priority: stall > PCSel > PCDelay > noop > advance
  always_comb begin
    pcf_d    = pcf_q;
    pcd_d    = pcd_q;
    dvalid_d = dvalid_q;
    instx_d  = instx_q;
    pcx_d    = pcx_q;
    validx_d = validx_q;
    state_d  = state_q;
    if (!stall) begin
      if (PCSel) begin
        // The word in flight belongs to the wrong path: squash it.
        pcf_d    = PCTarget & ~32'h3;
        dvalid_d = 1'b0;
        instx_d  = NOP_INST;
        validx_d = 1'b0;
        state_d  = S_RUN;
      end else if (PCDelay) begin
        // Fetch is frozen; the word on IMemDout stays parked for release.
        instx_d  = NOP_INST;
        validx_d = 1'b0;
        state_d  = S_HOLD;
      end else begin
        pcf_d    = pcf_q + 32'd4;
        pcd_d    = pcf_q;
        dvalid_d = 1'b1;
        pcx_d    = pcd_q;
        state_d  = S_RUN;
        if (noop || !dvalid_q) begin
          instx_d  = NOP_INST;
          validx_d = 1'b0;
        end else begin
          instx_d  = word;
          validx_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pcf_q    <= RESET_PC;
      pcd_q    <= RESET_PC;
      dvalid_q <= 1'b0;
      instx_q  <= NOP_INST;
      pcx_q    <= RESET_PC;
      validx_q <= 1'b0;
      state_q  <= S_BOOT;
    end else begin
      pcf_q    <= pcf_d;
      pcd_q    <= pcd_d;
      dvalid_q <= dvalid_d;
      instx_q  <= instx_d;
      pcx_q    <= pcx_d;
      validx_q <= validx_d;
      state_q  <= state_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_2000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        Clock;
  logic        Reset;
  logic        stall, PCDelay, noop, PCSel;
  logic [31:0] PCTarget;
  logic [31:0] IMemAddr;
  logic        IMemEn;
  logic [31:0] IMemDout;
  logic [31:0] PCF, InstX, PCX;
  logic        ValidX;

  int errors = 0;
  int checks = 0;

  fetch_stage #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
    .Clock(Clock), .Reset(Reset), .stall(stall), .PCDelay(PCDelay),
    .noop(noop), .PCSel(PCSel), .PCTarget(PCTarget),
    .IMemAddr(IMemAddr), .IMemEn(IMemEn), .IMemDout(IMemDout),
    .PCF(PCF), .InstX(InstX), .PCX(PCX), .ValidX(ValidX)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Program image: two fixed words, a hash everywhere else.
  function automatic logic [31:0] memf(input logic [31:0] a);
    if (a == 32'h0000_2000) return 32'h0050_0093;
    if (a == 32'h0000_2004) return 32'h0010_8113;
    return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
  endfunction

  // Synchronous imem, 1-cycle latency.
  always @(posedge Clock) begin
    if (IMemEn) IMemDout <= memf(IMemAddr);
`ifdef FETCH_SKID_BUF_EN
    else        IMemDout <= $urandom;
`endif
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Expected view of the stage during one cycle.
  typedef struct packed {
    logic [31:0] pcf;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        vld;
    logic        en;
  } exp_t;
  exp_t sb[$];

  // Reference model: fetch PC, the instruction currently in flight from
  // memory (by address), and the instruction sitting in X.
  logic [31:0] m_fpc, m_ipc, m_xinst, m_xpc;
  logic        m_ivld, m_xvld;

  task automatic model_reset();
    m_fpc = RST_PC; m_ipc = RST_PC; m_ivld = 1'b0;
    m_xinst = NOP; m_xpc = RST_PC; m_xvld = 1'b0;
  endtask

  // Apply one cycle of inputs, record what the DUT must show during it,
  // then advance the model across the clock edge.
  task automatic drive_cycle(input logic st, input logic sel, input logic dly,
                             input logic nop, input logic [31:0] tgt);
    exp_t e;
    stall = st; PCSel = sel; PCDelay = dly; noop = nop; PCTarget = tgt;
    e.pcf = m_fpc; e.inst = m_xinst; e.pc = m_xpc; e.vld = m_xvld;
    e.en  = !st && (sel || !dly);
    sb.push_back(e);
    if (!st) begin
      if (sel) begin
        m_fpc = tgt & ~32'h3; m_ivld = 1'b0;
        m_xinst = NOP; m_xvld = 1'b0;
      end else if (dly) begin
        m_xinst = NOP; m_xvld = 1'b0;
      end else begin
        if (m_ivld && !nop) begin
          m_xinst = memf(m_ipc); m_xvld = 1'b1;
        end else begin
          m_xinst = NOP; m_xvld = 1'b0;
        end
        m_xpc = m_ipc;
        m_ivld = 1'b1; m_ipc = m_fpc; m_fpc = m_fpc + 32'd4;
      end
    end
    @(posedge Clock); #1;
  endtask

  // Monitor: compares the DUT against the scoreboard every cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clock);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("PCF", PCF, e.pcf);
        chk("IMemAddr", IMemAddr, e.pcf);
        chk("IMemEn", {31'd0, IMemEn}, {31'd0, e.en});
        chk("ValidX", {31'd0, ValidX}, {31'd0, e.vld});
        chk("InstX", InstX, e.inst);
        if (e.vld) chk("PCX", PCX, e.pc);
      end
    end
  end

  task automatic rand_cycle();
    logic [31:0] t;
    int r;
    r = $urandom_range(0, 3);
    if (r == 0)      t = 32'hFFFF_FFFC | ($urandom & 32'h3);
    else if (r == 1) t = 32'h0000_2040;
    else             t = $urandom;
    drive_cycle($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 8,
                $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10, t);
  endtask

  initial begin
    stall = 0; PCDelay = 0; noop = 0; PCSel = 0; PCTarget = 0;
    Reset = 1'b1;
    #2 Reset = 1'b0;
    #1;
    chk("rst PCF", PCF, RST_PC);
    chk("rst PCX", PCX, RST_PC);
    chk("rst InstX", InstX, NOP);
    chk("rst ValidX", {31'd0, ValidX}, 32'd0);
    chk("rst IMemEn", {31'd0, IMemEn}, 32'd0);
    model_reset();
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b1;

    // Straight-line start, 2-cycle PCDelay, redirect from 0x2010 to 0x2040.
    repeat (4) drive_cycle(0, 0, 0, 0, 0);
    repeat (2) drive_cycle(0, 0, 1, 0, 0);
    drive_cycle(0, 1, 0, 0, 32'h0000_2040);
    repeat (4) drive_cycle(0, 0, 0, 0, 0);
    // 3-cycle stall with PCDelay/PCSel toggling underneath.
    drive_cycle(1, 1, 0, 0, 32'h0000_3000);
    drive_cycle(1, 0, 1, 0, 0);
    drive_cycle(1, 1, 1, 1, 32'h0000_4000);
    repeat (3) drive_cycle(0, 0, 0, 0, 0);
    // Wrap of PC at the top of the address space.
    drive_cycle(0, 1, 0, 0, 32'hFFFF_FFFE);
    repeat (4) drive_cycle(0, 0, 0, 0, 0);
    // noop and stall-on-valid-word cases.
    drive_cycle(0, 0, 0, 1, 0);
    repeat (2) drive_cycle(1, 0, 0, 0, 0);
    repeat (3) drive_cycle(0, 0, 0, 0, 0);

    repeat (400) rand_cycle();

    // Asynchronous reset in the middle of a hold.
    repeat (3) drive_cycle(0, 0, 0, 0, 0);
    repeat (2) drive_cycle(0, 0, 1, 0, 0);
    #2 Reset = 1'b0;
    #1;
    chk("async PCF", PCF, RST_PC);
    chk("async ValidX", {31'd0, ValidX}, 32'd0);
    chk("async InstX", InstX, NOP);
    chk("async IMemEn", {31'd0, IMemEn}, 32'd0);
    model_reset();
    @(posedge Clock); #1;
    Reset = 1'b1;
    repeat (6) drive_cycle(0, 0, 0, 0, 0);
    repeat (2) drive_cycle(0, 0, 1, 0, 0);
    repeat (4) drive_cycle(0, 0, 0, 0, 0);
    repeat (100) rand_cycle();

    repeat (4) @(negedge Clock);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
